// File: rtl/booth_r4_control_unit.sv
// Moore sequencer for the radix-4 Booth add-and-shift multiplier datapath.
// Strobes are registered copies of the decode of the next state, so every
// output is a flop with no combinational path from start or control.
module booth_r4_control_unit #(
  parameter int unsigned size = 8
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       start,
  input  logic [2:0] control,
  output logic       shifter_HI_shift_enable,
  output logic       shifter_HI_load_enable,
  output logic       shifter_HI_clear,
  output logic       shifter_LO_shift_enable,
  output logic       shifter_LO_load_enable,
  output logic       shifter_LO_clear,
  output logic       register_M_enable,
  output logic       register_M_clear,
  output logic       register_X_enable,
  output logic       register_X_clear,
  output logic       adder_enable,
  output logic [1:0] adder_mode,
  output logic       busy,
  output logic       done
);

  // size must be even and >= 2; one iteration retires two multiplier bits
  localparam int unsigned ITERS = size / 2;
  localparam int unsigned CNT_W = (ITERS < 2) ? 1 : $clog2(ITERS + 1);
  localparam int unsigned REP_W = 2;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ADD  = 2'b01;
  localparam logic [1:0] MODE_SUB  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL  = 3'd2,
    S_ADD   = 3'd3,
    S_WRHI  = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_mode_q, op_mode_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic [1:0]         rec_mode;
  logic [REP_W-1:0]   rec_reps;

  logic hi_shift_d, hi_load_d, hi_clear_d;
  logic lo_shift_d, lo_load_d, lo_clear_d;
  logic m_en_d, m_clear_d, x_en_d, x_clear_d;
  logic add_en_d, busy_d, done_d;
  logic [1:0] add_mode_d;

  // State, iteration bookkeeping and registered strobes
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q                 <= S_IDLE;
      cnt_q                   <= '0;
      op_mode_q               <= MODE_PASS;
      reps_q                  <= '0;
      shifter_HI_shift_enable <= 1'b0;
      shifter_HI_load_enable  <= 1'b0;
      shifter_HI_clear        <= 1'b0;
      shifter_LO_shift_enable <= 1'b0;
      shifter_LO_load_enable  <= 1'b0;
      shifter_LO_clear        <= 1'b0;
      register_M_enable       <= 1'b0;
      register_M_clear        <= 1'b0;
      register_X_enable       <= 1'b0;
      register_X_clear        <= 1'b0;
      adder_enable            <= 1'b0;
      adder_mode              <= MODE_PASS;
      busy                    <= 1'b0;
      done                    <= 1'b0;
    end else begin
      state_q                 <= state_d;
      cnt_q                   <= cnt_d;
      op_mode_q               <= op_mode_d;
      reps_q                  <= reps_d;
      shifter_HI_shift_enable <= hi_shift_d;
      shifter_HI_load_enable  <= hi_load_d;
      shifter_HI_clear        <= hi_clear_d;
      shifter_LO_shift_enable <= lo_shift_d;
      shifter_LO_load_enable  <= lo_load_d;
      shifter_LO_clear        <= lo_clear_d;
      register_M_enable       <= m_en_d;
      register_M_clear        <= m_clear_d;
      register_X_enable       <= x_en_d;
      register_X_clear        <= x_clear_d;
      adder_enable            <= add_en_d;
      adder_mode              <= add_mode_d;
      busy                    <= busy_d;
      done                    <= done_d;
    end
  end

  // Next state, Booth recoding and pass/iteration counters
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_mode_d = op_mode_q;
    reps_d    = reps_q;
    rec_mode  = MODE_PASS;
    rec_reps  = '0;

    // +-2M is done as two +-M passes since M has no shift path
    case (control)
      3'b001, 3'b010: begin rec_mode = MODE_ADD; rec_reps = REP_W'(1); end
      3'b011:         begin rec_mode = MODE_ADD; rec_reps = REP_W'(2); end
      3'b100:         begin rec_mode = MODE_SUB; rec_reps = REP_W'(2); end
      3'b101, 3'b110: begin rec_mode = MODE_SUB; rec_reps = REP_W'(1); end
      default:        begin rec_mode = MODE_PASS; rec_reps = '0; end
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        op_mode_d = rec_mode;
        reps_d    = rec_reps;
        state_d   = (rec_reps == '0) ? S_SHIFT : S_ADD;
      end
      S_ADD: begin
        state_d = S_WRHI;
      end
      S_WRHI: begin
        reps_d  = reps_q - REP_W'(1);
        state_d = (reps_q == REP_W'(1)) ? S_SHIFT : S_ADD;
      end
      S_SHIFT: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == CNT_W'(ITERS - 1)) ? S_DONE : S_EVAL;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobe decode of the state being entered
  always_comb begin
    hi_shift_d = 1'b0;
    hi_load_d  = 1'b0;
    hi_clear_d = 1'b0;
    lo_shift_d = 1'b0;
    lo_load_d  = 1'b0;
    lo_clear_d = 1'b0;
    m_en_d     = 1'b0;
    m_clear_d  = 1'b0;
    x_en_d     = 1'b0;
    x_clear_d  = 1'b0;
    add_en_d   = 1'b0;
    add_mode_d = MODE_PASS;
    busy_d     = (state_d != S_IDLE);
    done_d     = 1'b0;

    case (state_d)
      S_LOAD: begin
        lo_load_d  = 1'b1;
        m_en_d     = 1'b1;
        hi_clear_d = 1'b1;
        x_clear_d  = 1'b1;
      end
      S_ADD: begin
        add_en_d   = 1'b1;
        add_mode_d = op_mode_d;
      end
      S_WRHI: begin
        hi_load_d = 1'b1;
      end
      S_SHIFT: begin
        hi_shift_d = 1'b1;
        lo_shift_d = 1'b1;
        x_en_d     = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
